// File: rtl/onehot_span_decoder.sv
// Decodes a leftmost/rightmost one-hot word pair into binary bit indices and a
// contiguous span mask through a two-stage valid/ready pipeline.
module onehot_span_decoder #(
    parameter int WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic                     data_val_i,
    input  logic [WIDTH-1:0]         data_left_i,
    input  logic [WIDTH-1:0]         data_right_i,
    output logic                     data_rdy_o,
    output logic [$clog2(WIDTH)-1:0] left_idx_o,
    output logic [$clog2(WIDTH)-1:0] right_idx_o,
    output logic [WIDTH-1:0]         span_o,
    output logic                     zero_o,
    output logic                     err_o,
    output logic                     data_val_o,
    input  logic                     data_rdy_i
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONE  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] LSB_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 1);

    function automatic logic is_onehot(input logic [WIDTH-1:0] w);
        return (w != ALL_ZERO) && ((w & (w - LSB_ONE)) == ALL_ZERO);
    endfunction

    // OR-reduction of set-bit positions; exact only when w is one-hot.
    function automatic logic [IDX_W-1:0] enc_idx(input logic [WIDTH-1:0] w);
        logic [IDX_W-1:0] idx;
        idx = IDX_ZERO;
        for (int i = 0; i < WIDTH; i++) begin
            if (w[i]) begin
                idx = idx | IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [WIDTH-1:0] span_mask(input logic [IDX_W-1:0] l,
                                                   input logic [IDX_W-1:0] r);
        return (ALL_ONE << r) & (ALL_ONE >> (IDX_TOP - l));
    endfunction

    logic             s1_val_q, s1_val_d;
    logic [WIDTH-1:0] s1_left_q, s1_left_d;
    logic [WIDTH-1:0] s1_right_q, s1_right_d;
    logic             s2_val_q, s2_val_d;
    logic [IDX_W-1:0] left_idx_q, left_idx_d;
    logic [IDX_W-1:0] right_idx_q, right_idx_d;
    logic [WIDTH-1:0] span_q, span_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic             s2_adv_s, s1_adv_s, in_xfer_s;
    logic             dec_zero_s, dec_err_s;
    logic [IDX_W-1:0] dec_l_idx_s, dec_r_idx_s;
    logic [WIDTH-1:0] dec_span_s;

    // Pipeline advance conditions and the upstream ready.
    always_comb begin
        s2_adv_s   = ~s2_val_q | data_rdy_i;
        s1_adv_s   = ~s1_val_q | s2_adv_s;
        data_rdy_o = srst_i & s1_adv_s;
        in_xfer_s  = data_val_i & data_rdy_o;
    end

    // Stage 1 captures the raw word pair on an input transfer.
    always_comb begin
        s1_val_d   = s1_val_q;
        s1_left_d  = s1_left_q;
        s1_right_d = s1_right_q;
        if (s1_adv_s) begin
            s1_val_d = in_xfer_s;
        end else begin
            s1_val_d = s1_val_q;
        end
        if (in_xfer_s) begin
            s1_left_d  = data_left_i;
            s1_right_d = data_right_i;
        end else begin
            s1_left_d  = s1_left_q;
            s1_right_d = s1_right_q;
        end
    end

    // Decode of the stage-1 pair; malformed or empty pairs give zero indices and span.
    always_comb begin
        logic l_oh, r_oh;
        logic [IDX_W-1:0] l_raw, r_raw;
        l_oh        = is_onehot(s1_left_q);
        r_oh        = is_onehot(s1_right_q);
        l_raw       = l_oh ? enc_idx(s1_left_q) : IDX_ZERO;
        r_raw       = r_oh ? enc_idx(s1_right_q) : IDX_ZERO;
        dec_zero_s  = (s1_left_q == ALL_ZERO) && (s1_right_q == ALL_ZERO);
        dec_err_s   = ~dec_zero_s && (~(l_oh && r_oh) || (l_raw < r_raw));
        dec_l_idx_s = IDX_ZERO;
        dec_r_idx_s = IDX_ZERO;
        dec_span_s  = ALL_ZERO;
        if (~dec_zero_s && ~dec_err_s) begin
            dec_l_idx_s = l_raw;
            dec_r_idx_s = r_raw;
            dec_span_s  = span_mask(l_raw, r_raw);
        end else begin
            dec_l_idx_s = IDX_ZERO;
            dec_r_idx_s = IDX_ZERO;
            dec_span_s  = ALL_ZERO;
        end
    end

    // Stage 2 output registers; a bubble loads zeros so no stale data lingers.
    always_comb begin
        s2_val_d    = s2_val_q;
        left_idx_d  = left_idx_q;
        right_idx_d = right_idx_q;
        span_d      = span_q;
        zero_d      = zero_q;
        err_d       = err_q;
        if (s2_adv_s) begin
            s2_val_d = s1_val_q;
            if (s1_val_q) begin
                left_idx_d  = dec_l_idx_s;
                right_idx_d = dec_r_idx_s;
                span_d      = dec_span_s;
                zero_d      = dec_zero_s;
                err_d       = dec_err_s;
            end else begin
                left_idx_d  = IDX_ZERO;
                right_idx_d = IDX_ZERO;
                span_d      = ALL_ZERO;
                zero_d      = 1'b0;
                err_d       = 1'b0;
            end
        end else begin
            s2_val_d = s2_val_q;
        end
    end

    // State update with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            s1_val_q    <= 1'b0;
            s1_left_q   <= ALL_ZERO;
            s1_right_q  <= ALL_ZERO;
            s2_val_q    <= 1'b0;
            left_idx_q  <= IDX_ZERO;
            right_idx_q <= IDX_ZERO;
            span_q      <= ALL_ZERO;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            s1_val_q    <= s1_val_d;
            s1_left_q   <= s1_left_d;
            s1_right_q  <= s1_right_d;
            s2_val_q    <= s2_val_d;
            left_idx_q  <= left_idx_d;
            right_idx_q <= right_idx_d;
            span_q      <= span_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
        end
    end

    assign data_val_o  = s2_val_q;
    assign left_idx_o  = left_idx_q;
    assign right_idx_o = right_idx_q;
    assign span_o      = span_q;
    assign zero_o      = zero_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_onehot_span_decoder.sv
// Directed bench for onehot_span_decoder at WIDTH=8: decode table, streaming,
// backpressure and mid-flight reset.
module tb_onehot_span_decoder;

    logic       clk_i = 1'b0;
    logic       srst_i;
    logic       data_val_i;
    logic [7:0] data_left_i;
    logic [7:0] data_right_i;
    logic       data_rdy_o;
    logic [2:0] left_idx_o;
    logic [2:0] right_idx_o;
    logic [7:0] span_o;
    logic       zero_o;
    logic       err_o;
    logic       data_val_o;
    logic       data_rdy_i;

    int errors = 0;
    int checks = 0;

    onehot_span_decoder #(.WIDTH(8)) dut (
        .clk_i        (clk_i),
        .srst_i       (srst_i),
        .data_val_i   (data_val_i),
        .data_left_i  (data_left_i),
        .data_right_i (data_right_i),
        .data_rdy_o   (data_rdy_o),
        .left_idx_o   (left_idx_o),
        .right_idx_o  (right_idx_o),
        .span_o       (span_o),
        .zero_o       (zero_o),
        .err_o        (err_o),
        .data_val_o   (data_val_o),
        .data_rdy_i   (data_rdy_i)
    );

    always #5 clk_i = ~clk_i;

    // Packed layout used throughout: {val, left_idx, right_idx, span, zero, err}.
    localparam int NV = 10;
    localparam logic [7:0] TL [NV] = '{8'h20, 8'h80, 8'h10, 8'h00, 8'h30,
                                       8'h02, 8'h04, 8'h00, 8'h01, 8'h80};
    localparam logic [7:0] TR [NV] = '{8'h04, 8'h01, 8'h10, 8'h00, 8'h01,
                                       8'h08, 8'h00, 8'h04, 8'h01, 8'h80};
    localparam logic [15:0] TE [NV] = '{
        {3'd5, 3'd2, 8'h3C, 1'b0, 1'b0},
        {3'd7, 3'd0, 8'hFF, 1'b0, 1'b0},
        {3'd4, 3'd4, 8'h10, 1'b0, 1'b0},
        {3'd0, 3'd0, 8'h00, 1'b1, 1'b0},
        {3'd0, 3'd0, 8'h00, 1'b0, 1'b1},
        {3'd0, 3'd0, 8'h00, 1'b0, 1'b1},
        {3'd0, 3'd0, 8'h00, 1'b0, 1'b1},
        {3'd0, 3'd0, 8'h00, 1'b0, 1'b1},
        {3'd0, 3'd0, 8'h01, 1'b0, 1'b0},
        {3'd7, 3'd7, 8'h80, 1'b0, 1'b0}
    };

    // Bit-scanning reference for generated streams.
    function automatic logic [15:0] model(input logic [7:0] l, input logic [7:0] r);
        int cl = 0;
        int cr = 0;
        int pl = 0;
        int pr = 0;
        logic [7:0] sp = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (l[i]) begin cl++; pl = i; end
            if (r[i]) begin cr++; pr = i; end
        end
        if (cl == 0 && cr == 0) return {3'd0, 3'd0, 8'h00, 1'b1, 1'b0};
        if (cl != 1 || cr != 1 || pl < pr) return {3'd0, 3'd0, 8'h00, 1'b0, 1'b1};
        for (int k = pr; k <= pl; k++) sp[k] = 1'b1;
        return {3'(pl), 3'(pr), sp, 1'b0, 1'b0};
    endfunction

    function automatic logic [16:0] obs();
        return {data_val_o, left_idx_o, right_idx_o, span_o, zero_o, err_o};
    endfunction

    task automatic test_reset();
        srst_i = 1'b0; data_val_i = 1'b0; data_rdy_i = 1'b1;
        data_left_i = 8'h00; data_right_i = 8'h00;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({data_rdy_o, obs()} !== 18'h0) begin
            errors++;
            $display("FAIL reset_hold: rdy=%b out=%h required rdy=0 out=0", data_rdy_o, obs());
        end
        srst_i = 1'b1;
        #1;
        checks++;
        if ({data_rdy_o, data_val_o} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: rdy=%b val=%b required rdy=1 val=0", data_rdy_o, data_val_o);
        end
    endtask

    task automatic test_decode();
        for (int v = 0; v < NV; v++) begin
            @(posedge clk_i); #1;
            data_rdy_i = 1'b1; data_val_i = 1'b1;
            data_left_i = TL[v]; data_right_i = TR[v];
            @(posedge clk_i); #1;
            data_val_i = 1'b0;
            checks++;
            if (data_val_o !== 1'b0) begin
                errors++;
                $display("FAIL decode_early[%0d]: val=%b required 0", v, data_val_o);
            end
            @(posedge clk_i); #1;
            checks++;
            if (obs() !== {1'b1, TE[v]}) begin
                errors++;
                $display("FAIL decode[%0d] l=%h r=%h: out=%h required %h",
                         v, TL[v], TR[v], obs(), {1'b1, TE[v]});
            end
        end
    endtask

    task automatic test_stream();
        logic [7:0] sl [16];
        logic [7:0] sr [16];
        for (int k = 0; k < 16; k++) begin
            sl[k] = 8'h01 << ((k * 3) % 8);
            sr[k] = 8'h01 << ((k * 5) % 8);
        end
        for (int k = 0; k < 19; k++) begin
            @(posedge clk_i); #1;
            data_rdy_i = 1'b1;
            if (k < 16) begin
                data_val_i = 1'b1; data_left_i = sl[k]; data_right_i = sr[k];
            end else begin
                data_val_i = 1'b0;
            end
            #1;
            checks++;
            if (k >= 2 && k < 18) begin
                if ({data_rdy_o, obs()} !== {1'b1, 1'b1, model(sl[k-2], sr[k-2])}) begin
                    errors++;
                    $display("FAIL stream[%0d]: rdy=%b out=%h required rdy=1 out=%h",
                             k, data_rdy_o, obs(), {1'b1, model(sl[k-2], sr[k-2])});
                end
            end else if ({data_rdy_o, data_val_o} !== 2'b10) begin
                errors++;
                $display("FAIL stream_idle[%0d]: rdy=%b val=%b required rdy=1 val=0",
                         k, data_rdy_o, data_val_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bl [4] = '{8'h20, 8'h80, 8'h10, 8'h40};
        logic [7:0] br [4] = '{8'h04, 8'h01, 8'h10, 8'h02};
        int sent = 0;
        int outs = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk_i); #1;
            data_rdy_i = (k >= 3);
            if (sent < 4) begin
                data_val_i = 1'b1; data_left_i = bl[sent]; data_right_i = br[sent];
            end else begin
                data_val_i = 1'b0;
            end
            #1;
            if (k == 2) begin
                checks++;
                if (data_rdy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_full_rdy: rdy=%b required 0", data_rdy_o);
                end
            end
            if (data_val_o) begin
                checks++;
                if (outs >= 4) begin
                    errors++;
                    $display("FAIL bp_extra: out=%h required no output", obs());
                end else if (obs() !== {1'b1, model(bl[outs], br[outs])}) begin
                    errors++;
                    $display("FAIL bp_word[%0d] cyc%0d: out=%h required %h",
                             outs, k, obs(), {1'b1, model(bl[outs], br[outs])});
                end
                if (data_rdy_i) outs++;
            end
            if (data_val_i && data_rdy_o) sent++;
        end
        checks++;
        if (sent !== 4 || outs !== 4) begin
            errors++;
            $display("FAIL bp_count: sent=%0d out=%0d required 4 and 4", sent, outs);
        end
    endtask

    task automatic test_reset_midflight();
        @(posedge clk_i); #1;
        data_rdy_i = 1'b0; data_val_i = 1'b1;
        data_left_i = 8'h20; data_right_i = 8'h04;
        @(posedge clk_i); #1;
        data_left_i = 8'h80; data_right_i = 8'h01;
        @(posedge clk_i); #1;
        srst_i = 1'b0; data_rdy_i = 1'b1;
        data_left_i = 8'h10; data_right_i = 8'h10;
        #1;
        checks++;
        if (data_rdy_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_rdy: rdy=%b required 0", data_rdy_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if ({data_rdy_o, obs()} !== 18'h0) begin
            errors++;
            $display("FAIL rst_mid_clear: rdy=%b out=%h required rdy=0 out=0", data_rdy_o, obs());
        end
        srst_i = 1'b1; data_val_i = 1'b0;
        #1;
        checks++;
        if (data_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_release: rdy=%b required 1", data_rdy_o);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i); #1;
            checks++;
            if (obs() !== 17'h0) begin
                errors++;
                $display("FAIL rst_mid_stale[%0d]: out=%h required 0", k, obs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_stream();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
